// File: rtl/la_code_if.sv
// Address/data bus of the 5x5 matrix capture block.
// value[r-1][c-1] carries A[r][c] (value11..value55); valued[r-1][c-1] carries valueRCd.
interface la_code_if;
  logic [4:0]            address;
  logic [31:0]           data_out;
  logic [4:0][4:0][31:0] value;
  logic [4:0][4:0][31:0] valued;

  modport master (output address, input data_out, value, valued);
  modport slave  (input address, output data_out, value, valued);
endinterface

// File: rtl/la_code.sv
// 5x5 coefficient-ROM matrix capture: loads A element-by-element from a fixed ROM
// and keeps a registered transpose bank one clock behind it.

// One matrix element: its A register plus the A^T register fed from the mirrored cell.
module la_cell (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [31:0] din,
  input  logic [31:0] tin,
  output logic [31:0] val,
  output logic [31:0] vald
);
  always_ff @(posedge clk) begin
    if (reset) begin
      val  <= '0;
      vald <= '0;
    end else begin
      if (wr) val <= din;
      vald <= tin;
    end
  end
endmodule

module la_code #(
  parameter logic [31:0] ROM_BASE = 32'd1
) (
  input  logic       clk,
  input  logic       reset,
  la_code_if.slave   bus
);
  localparam int N = 5;

  logic                  in_range;
  logic [31:0]           rom_word;
  logic [N-1:0][N-1:0][31:0] val;
  logic [N-1:0][N-1:0][31:0] vald;

  // ROM is rom[k] = ROM_BASE + k; addresses 25..31 read as zero and write nothing.
  always_comb begin
    in_range = (bus.address < 5'd25);
    rom_word = in_range ? (ROM_BASE + 32'(bus.address)) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) bus.data_out <= '0;
    else       bus.data_out <= rom_word;
  end

  // Cell (r,c) samples the mirrored cell (c,r) for its transpose entry.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      la_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .wr    (in_range && (bus.address == 5'(N*r + c))),
        .din   (rom_word),
        .tin   (val[c][r]),
        .val   (val[r][c]),
        .vald  (vald[r][c])
      );
    end
  end

  assign bus.value  = val;
  assign bus.valued = vald;
endmodule

// File: tb/tb_la_code.sv
// Directed bench for la_code: vector table for the row-major sweep plus hand sequences
// for reset, out-of-range and transpose latency, cross-checked against a small bank model.
module tb_la_code;
  logic clk = 1'b0;
  logic reset;
  la_code_if bus ();

  la_code #(.ROM_BASE(32'd1)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp_data;
    int          r;
    int          c;
  } vec_t;

  vec_t        vecs[25];
  int          nvec = 0;
  int          nbad = 0;
  logic [31:0] ma[5][5];
  logic [31:0] mat[5][5];

  // Reference model of both banks, updated once per applied edge.
  task automatic model(input logic rst, input logic [4:0] addr);
    logic [31:0] old[5][5];
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) old[i][j] = ma[i][j];
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        if (rst) begin
          ma[i][j]  = '0;
          mat[i][j] = '0;
        end else
          mat[i][j] = old[j][i];
      end
    if (!rst && addr < 5'd25) ma[int'(addr) / 5][int'(addr) % 5] = 32'(addr) + 32'd1;
  endtask

  task automatic step(input logic rst, input logic [4:0] addr);
    @(negedge clk);
    reset       = rst;
    bus.address = addr;
    @(posedge clk);
    #1;
    model(rst, addr);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_bank(input string name);
    int bad = 0;
    nvec++;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        if (bad == 0 && bus.value[i][j] !== ma[i][j]) begin
          bad = 1;
          $display("FAIL %s: value%0d%0d got %0d expected %0d", name, i+1, j+1, bus.value[i][j], ma[i][j]);
        end
        if (bad == 0 && bus.valued[i][j] !== mat[i][j]) begin
          bad = 1;
          $display("FAIL %s: value%0d%0dd got %0d expected %0d", name, i+1, j+1, bus.valued[i][j], mat[i][j]);
        end
      end
    nbad += bad;
  endtask

  initial begin
    for (int i = 0; i < 25; i++) vecs[i] = '{5'(i), 32'(i + 1), i / 5, i % 5};
    reset       = 1'b1;
    bus.address = 5'd0;

    // Reset state
    step(1'b1, 5'd0);
    step(1'b1, 5'd0);
    chk("rst_data", bus.data_out, 32'd0);
    chk_bank("rst_bank");

    // First element and its transpose latency
    step(1'b0, 5'd0);
    chk("a0_data", bus.data_out, 32'd1);
    chk("a0_v11", bus.value[0][0], 32'd1);
    chk("a0_v11d", bus.valued[0][0], 32'd0);
    step(1'b0, 5'd1);
    chk("a1_data", bus.data_out, 32'd2);
    chk("a1_v12", bus.value[0][1], 32'd2);
    chk("a1_v11d", bus.valued[0][0], 32'd1);
    step(1'b0, 5'd25);
    chk("a1_v21d", bus.valued[1][0], 32'd2);
    chk("a1_v12d", bus.valued[0][1], 32'd0);
    chk_bank("a1_bank");

    // Row-major sweep from the vector table
    for (int i = 0; i < 25; i++) begin
      step(1'b0, vecs[i].addr);
      chk($sformatf("sweep%0d_data", i), bus.data_out, vecs[i].exp_data);
      chk($sformatf("sweep%0d_val", i), bus.value[vecs[i].r][vecs[i].c], vecs[i].exp_data);
    end
    chk("sweep_v53", bus.value[4][2], 32'd23);
    chk("sweep_v55", bus.value[4][4], 32'd25);
    chk_bank("sweep_bank");

    // Out of range after the sweep: zero read, banks frozen
    step(1'b0, 5'd25);
    chk("oor25_data", bus.data_out, 32'd0);
    chk("sweep_v35d", bus.valued[2][4], 32'd23);
    chk("sweep_v15d", bus.valued[0][4], 32'd21);
    chk("sweep_v51d", bus.valued[4][0], 32'd5);
    chk("sweep_v55d", bus.valued[4][4], 32'd25);
    for (int a = 26; a < 32; a++) begin
      step(1'b0, 5'(a));
      chk($sformatf("oor%0d_data", a), bus.data_out, 32'd0);
      chk_bank($sformatf("oor%0d_bank", a));
    end

    // Reset mid-stream, then a single reload
    step(1'b1, 5'd12);
    chk("rst2_data", bus.data_out, 32'd0);
    chk_bank("rst2_bank");
    step(1'b0, 5'd12);
    chk("r12_v33", bus.value[2][2], 32'd13);
    chk("r12_v33d_early", bus.valued[2][2], 32'd0);
    step(1'b0, 5'd25);
    chk("r12_v33d", bus.valued[2][2], 32'd13);
    chk_bank("r12_bank");

    // Reset with a live address: reset wins
    step(1'b1, 5'd7);
    chk("rstw_data", bus.data_out, 32'd0);
    chk("rstw_v23", bus.value[1][2], 32'd0);
    chk_bank("rstw_bank");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
